hrv_window_classifier: RTL and testbench
========================================

HRV_WINDOW_CLASSIFIER -- requirements
Module: hrv_window_classifier

Interface
REQ-001 SHALL have parameter RR_W, default 12, RR interval width in ms.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, log2 of rolling-window depth (DEPTH = 2^DEPTH_LOG2).
REQ-003 SHALL have parameter BRADY_MS, default 1000, brady threshold (rr > BRADY_MS gives brady).
REQ-004 SHALL have parameter TACHY_MS, default 600, tachy threshold (rr < TACHY_MS gives tachy).
REQ-005 SHALL have parameter IRREG_SHIFT, default 3, irregularity tolerance = mean >> IRREG_SHIFT.
REQ-006 SHALL have parameter CNT_W, default 16, event counter width.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 clear  input  1  synchronous clear of window, counters and state.
REQ-010 rr_valid  input  1  one-cycle strobe, new RR interval present.
REQ-011 rr_ms  input  RR_W  RR interval in ms.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 res_valid  output  1  result available.
REQ-015 res_class  output  2  00 normal, 01 brady, 10 tachy; 11 never driven.
REQ-016 res_irreg  output  1  beat irregular relative to window mean.
REQ-017 mean_ms  output  RR_W  window mean.
REQ-018 window_full  output  1  DEPTH beats stored.
REQ-019 brady_cnt, tachy_cnt, irreg_cnt  output  CNT_W each  event counts.
REQ-020 overrun  output  1  sticky flag, beat dropped.

Function
REQ-021 SHALL implement FSM IDLE -> CALC -> EMIT -> IDLE.
REQ-022 In IDLE, rr_valid with rr_ms != 0 SHALL be accepted: write the circular buffer at wr_ptr, increment wr_ptr modulo DEPTH, go to CALC.
REQ-023 rr_valid with rr_ms == 0 SHALL be ignored with no state change and no overrun.
REQ-024 In CALC, sum SHALL become sum + rr - oldest, where oldest = 0 until window_full; sum width = RR_W + DEPTH_LOG2, no overflow possible.
REQ-025 fill count SHALL saturate at DEPTH; window_full = (fill == DEPTH).
REQ-026 mean_ms SHALL equal sum >> DEPTH_LOG2 when window_full, else the latest accepted rr; it updates on the CALC -> EMIT edge.
REQ-027 On entering EMIT, res_valid SHALL assert exactly 2 cycles after the acceptance edge.
REQ-028 res_class SHALL be derived from the current rr with strict compares; rr == TACHY_MS and rr == BRADY_MS are normal.
REQ-029 res_irreg SHALL be 1 only when window_full and |rr - mean_ms| > (mean_ms >> IRREG_SHIFT), using the updated mean.
REQ-030 res_valid, res_class and res_irreg SHALL hold stable until a cycle with res_valid && res_ready; the FSM then returns to IDLE and res_valid deasserts on the next cycle.
REQ-031 Counters SHALL increment once per emitted result on the handshake cycle, matching res_class/res_irreg, and saturate at 2^CNT_W-1.
REQ-032 rr_valid (rr_ms != 0) while busy SHALL drop the beat and set overrun; overrun clears only on rst or clear.
REQ-033 clear SHALL have priority over rr_valid and handshake: zero fill, sum, wr_ptr, counters, overrun, mean_ms; go to IDLE; res_valid low next cycle.

Reset
REQ-034 On rst, all outputs SHALL be 0 and the FSM in IDLE; buffer contents are don't-care because fill = 0 masks them.
REQ-035 Deassertion of rst SHALL take effect on the next clk edge with no spurious res_valid.

Verification
REQ-036 Reset: assert rst mid-EMIT -> res_valid, busy, counters, and mean_ms all 0 immediately.
REQ-037 Fill: 8 beats of 800 (res_ready=1) -> window_full=1 after the 8th, mean_ms=800, res_class=00, res_irreg=0, all counters 0.
REQ-038 Irregular: after the fill, 400 -> mean_ms=750, res_class=10, res_irreg=1 (350 > 93), tachy_cnt=1, irreg_cnt=1.
REQ-039 Boundaries: rr=600 -> 00; rr=1000 -> 00; rr=1001 -> 01; rr=599 -> 10; rr=0 -> no response.
REQ-040 Backpressure: res_ready=0 for 5 cycles plus rr_valid during EMIT -> result held stable, overrun=1, dropped beat absent from sum and counters.
REQ-041 Saturation and clear: CNT_W=2, 5 brady beats -> brady_cnt=3; pulse clear -> all counters 0, window_full=0, busy=0.

Source files
------------

// File: rtl/hrv_window_classifier.sv
// Heart-rate-variability beat classifier. It keeps a rolling window of RR intervals,
// then emits a brady/tachy/normal class and an irregularity flag for each accepted beat.
module hrv_window_classifier #(
    parameter int unsigned RR_W        = 12,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned BRADY_MS    = 1000,
    parameter int unsigned TACHY_MS    = 600,
    parameter int unsigned IRREG_SHIFT = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             rr_valid,
    input  logic [RR_W-1:0]  rr_ms,
    input  logic             res_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [1:0]       res_class,
    output logic             res_irreg,
    output logic [RR_W-1:0]  mean_ms,
    output logic             window_full,
    output logic [CNT_W-1:0] brady_cnt,
    output logic [CNT_W-1:0] tachy_cnt,
    output logic [CNT_W-1:0] irreg_cnt,
    output logic             overrun
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W  = RR_W + DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t                state;
    logic [RR_W-1:0]       rr_buf [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]     fill;
    logic [SUM_W-1:0]      sum;
    logic [RR_W-1:0]       cur_rr;
    logic [RR_W-1:0]       oldest;

    logic                  beat_c;
    logic                  accept_c;
    logic                  handshake_c;
    logic [SUM_W-1:0]      sum_next_c;
    logic [FILL_W-1:0]     fill_next_c;
    logic                  full_next_c;
    logic [RR_W-1:0]       mean_next_c;
    logic [RR_W-1:0]       diff_c;
    logic                  irreg_c;
    logic [1:0]            class_c;

    // Window update and classification of the beat being processed in CALC
    always_comb begin
        beat_c      = rr_valid && (rr_ms != '0);
        accept_c    = beat_c && (state == IDLE);
        handshake_c = (state == EMIT) && res_valid && res_ready;
        sum_next_c  = sum + SUM_W'(cur_rr) - SUM_W'(oldest);
        fill_next_c = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
        full_next_c = (fill_next_c == FILL_W'(DEPTH));
        mean_next_c = full_next_c ? RR_W'(sum_next_c >> DEPTH_LOG2) : cur_rr;
        diff_c      = (cur_rr >= mean_next_c) ? cur_rr - mean_next_c : mean_next_c - cur_rr;
        irreg_c     = full_next_c && (diff_c > (mean_next_c >> IRREG_SHIFT));
        class_c     = 2'b00;
        if (cur_rr > RR_W'(BRADY_MS)) begin
            class_c = 2'b01;
        end else if (cur_rr < RR_W'(TACHY_MS)) begin
            class_c = 2'b10;
        end
    end

    // Beat storage needs no reset: entries beyond fill are never read
    always_ff @(posedge clk) begin
        if (accept_c && !clear) begin
            rr_buf[wr_ptr] <= rr_ms;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            cur_rr      <= '0;
            oldest      <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_class   <= 2'b00;
            res_irreg   <= 1'b0;
            mean_ms     <= '0;
            window_full <= 1'b0;
            brady_cnt   <= '0;
            tachy_cnt   <= '0;
            irreg_cnt   <= '0;
            overrun     <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            cur_rr      <= '0;
            oldest      <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_class   <= 2'b00;
            res_irreg   <= 1'b0;
            mean_ms     <= '0;
            window_full <= 1'b0;
            brady_cnt   <= '0;
            tachy_cnt   <= '0;
            irreg_cnt   <= '0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        // The evicted beat only counts once the window has wrapped
                        oldest <= (fill == FILL_W'(DEPTH)) ? rr_buf[wr_ptr] : '0;
                        cur_rr <= rr_ms;
                        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (beat_c) begin
                        overrun <= 1'b1;
                    end
                    sum         <= sum_next_c;
                    fill        <= fill_next_c;
                    window_full <= full_next_c;
                    mean_ms     <= mean_next_c;
                    res_class   <= class_c;
                    res_irreg   <= irreg_c;
                    res_valid   <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (beat_c) begin
                        overrun <= 1'b1;
                    end
                    if (handshake_c) begin
                        if (res_class == 2'b01 && brady_cnt != '1) begin
                            brady_cnt <= brady_cnt + CNT_W'(1);
                        end
                        if (res_class == 2'b10 && tachy_cnt != '1) begin
                            tachy_cnt <= tachy_cnt + CNT_W'(1);
                        end
                        if (res_irreg && irreg_cnt != '1) begin
                            irreg_cnt <= irreg_cnt + CNT_W'(1);
                        end
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hrv_window_classifier.sv
// Self-checking bench for hrv_window_classifier: directed tables and sequences, plus randomized
// beats compared against a queue-based reference of the rolling window.
module tb_hrv_window_classifier;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        rr_valid;
    logic [11:0] rr_ms;
    logic        res_ready;

    logic        busy, res_valid, res_irreg, window_full, overrun;
    logic [1:0]  res_class;
    logic [11:0] mean_ms;
    logic [15:0] brady_cnt, tachy_cnt, irreg_cnt;

    logic        b2_busy, b2_res_valid, b2_res_irreg, b2_window_full, b2_overrun;
    logic [1:0]  b2_res_class;
    logic [11:0] b2_mean_ms;
    logic [1:0]  b2_brady_cnt, b2_tachy_cnt, b2_irreg_cnt;

    int checks   = 0;
    int failures = 0;

    int q[$];
    int m_brady, m_tachy, m_irreg, m_brady2;
    int e_class, e_irreg, e_mean, e_full;

    typedef struct {
        int rr;
        int cls;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    hrv_window_classifier dut (
        .clk(clk), .rst(rst), .clear(clear), .rr_valid(rr_valid), .rr_ms(rr_ms),
        .res_ready(res_ready), .busy(busy), .res_valid(res_valid), .res_class(res_class),
        .res_irreg(res_irreg), .mean_ms(mean_ms), .window_full(window_full),
        .brady_cnt(brady_cnt), .tachy_cnt(tachy_cnt), .irreg_cnt(irreg_cnt), .overrun(overrun)
    );

    hrv_window_classifier #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .rr_valid(rr_valid), .rr_ms(rr_ms),
        .res_ready(res_ready), .busy(b2_busy), .res_valid(b2_res_valid), .res_class(b2_res_class),
        .res_irreg(b2_res_irreg), .mean_ms(b2_mean_ms), .window_full(b2_window_full),
        .brady_cnt(b2_brady_cnt), .tachy_cnt(b2_tachy_cnt), .irreg_cnt(b2_irreg_cnt),
        .overrun(b2_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_brady  = 0;
        m_tachy  = 0;
        m_irreg  = 0;
        m_brady2 = 0;
    endfunction

    function automatic void model_accept(input int rr);
        int s;
        int diff;
        q.push_back(rr);
        if (q.size() > DEPTH) void'(q.pop_front());
        e_full = (q.size() == DEPTH) ? 1 : 0;
        s = 0;
        foreach (q[i]) s += q[i];
        e_mean  = (e_full == 1) ? s / DEPTH : rr;
        e_class = (rr > 1000) ? 1 : ((rr < 600) ? 2 : 0);
        diff    = (rr > e_mean) ? rr - e_mean : e_mean - rr;
        e_irreg = (e_full == 1 && diff > e_mean / 8) ? 1 : 0;
    endfunction

    function automatic void model_handshake();
        if (e_class == 1) begin
            m_brady++;
            m_brady2 = (m_brady2 < 3) ? m_brady2 + 1 : 3;
        end
        if (e_class == 2) m_tachy++;
        if (e_irreg == 1) m_irreg++;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_brady"}, 32'(brady_cnt), m_brady);
        check({tag, "_tachy"}, 32'(tachy_cnt), m_tachy);
        check({tag, "_irreg"}, 32'(irreg_cnt), m_irreg);
        check({tag, "_brady2"}, 32'(b2_brady_cnt), m_brady2);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_class"}, 32'(res_class), e_class);
        check({tag, "_irreg"}, 32'(res_irreg), e_irreg);
        check({tag, "_mean"}, 32'(mean_ms), e_mean);
        check({tag, "_full"}, 32'(window_full), e_full);
    endtask

    // Called right after a clock edge with the DUT idle; ends right after the handshake edge
    task automatic send_beat(input int rr, input int hold);
        int lat;
        res_ready = (hold == 0);
        rr_valid  = 1'b1;
        rr_ms     = 12'(rr);
        @(posedge clk); #1;
        rr_valid = 1'b0;
        rr_ms    = '0;
        lat = 1;
        while (!res_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 2);
        check("busy_emit", 32'(busy), 1);
        model_accept(rr);
        check_result("beat");
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(res_valid), 1);
            check("hold_class", 32'(res_class), e_class);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        model_handshake();
        check("valid_drop", 32'(res_valid), 0);
        check_counts("cnt");
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        clear     = 1'b0;
        rr_valid  = 1'b0;
        rr_ms     = '0;
        res_ready = 1'b0;
        vecs[0] = '{600, 0};
        vecs[1] = '{1000, 0};
        vecs[2] = '{1001, 1};
        vecs[3] = '{599, 2};
        vecs[4] = '{800, 0};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_class", 32'(res_class), 0);
        check("rst_mean", 32'(mean_ms), 0);
        check("rst_full", 32'(window_full), 0);
        check("rst_overrun", 32'(overrun), 0);
        check_counts("rst");
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("no_spurious", 32'(res_valid), 0);
        end

        // Fill the window with a steady rhythm
        for (int i = 0; i < 8; i++) send_beat(800, 0);
        check("fill_full", 32'(window_full), 1);
        check("fill_mean", 32'(mean_ms), 800);
        check("fill_class", 32'(res_class), 0);
        check("fill_irreg", 32'(res_irreg), 0);
        check("fill_brady", 32'(brady_cnt), 0);

        send_beat(400, 0);
        check("irr_mean", 32'(mean_ms), 750);
        check("irr_class", 32'(res_class), 2);
        check("irr_irreg", 32'(res_irreg), 1);
        check("irr_tachy", 32'(tachy_cnt), 1);
        check("irr_cnt", 32'(irreg_cnt), 1);

        for (int i = 0; i < 5; i++) begin
            send_beat(vecs[i].rr, i % 2);
            check("table_class", 32'(res_class), vecs[i].cls);
        end

        // A zero interval is ignored entirely
        rr_valid = 1'b1;
        rr_ms    = '0;
        @(posedge clk); #1;
        rr_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("zero_busy", 32'(busy), 0);
            check("zero_valid", 32'(res_valid), 0);
        end
        check("zero_overrun", 32'(overrun), 0);

        // Backpressure with a beat arriving while the result is held
        res_ready = 1'b0;
        rr_valid  = 1'b1;
        rr_ms     = 12'd900;
        @(posedge clk); #1;
        rr_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 2);
        model_accept(900);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                rr_valid = 1'b1;
                rr_ms    = 12'd1200;
            end
            @(posedge clk); #1;
            rr_valid = 1'b0;
            check("bp_valid", 32'(res_valid), 1);
            check_result("bp");
        end
        check("bp_overrun", 32'(overrun), 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        model_handshake();
        check("bp_release", 32'(res_valid), 0);
        check_counts("bp");
        send_beat(800, 0);
        check("overrun_sticky", 32'(overrun), 1);

        for (int i = 0; i < 40; i++) begin
            send_beat(int'($urandom_range(1500, 300)), int'($urandom_range(3, 0)));
        end

        // Asynchronous reset while a result is held
        res_ready = 1'b0;
        rr_valid  = 1'b1;
        rr_ms     = 12'd1100;
        @(posedge clk); #1;
        rr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(res_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(res_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_mean", 32'(mean_ms), 0);
        check("arst_overrun", 32'(overrun), 0);
        model_reset();
        check_counts("arst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_valid", 32'(res_valid), 0);
        end

        // Counter saturation on the narrow instance, then clear beating a new beat
        for (int i = 0; i < 5; i++) send_beat(1200, 0);
        check("sat_brady16", 32'(brady_cnt), 5);
        check("sat_brady2", 32'(b2_brady_cnt), 3);
        check("sat_tachy2", 32'(b2_tachy_cnt), 0);
        clear    = 1'b1;
        rr_valid = 1'b1;
        rr_ms    = 12'd700;
        @(posedge clk); #1;
        clear    = 1'b0;
        rr_valid = 1'b0;
        model_reset();
        check_counts("clr");
        check("clr_full", 32'(window_full), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_valid", 32'(res_valid), 0);
        check("clr_mean", 32'(mean_ms), 0);
        check("clr_b2_busy", 32'(b2_busy), 0);
        send_beat(700, 0);
        check("clr_refill_mean", 32'(mean_ms), 700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
